// File: rtl/wrr_arbiter_param_pkg.sv
// Shared types and helpers for the parametrised weighted round-robin arbiter.
package wrr_arbiter_param_pkg;

    localparam int unsigned DEF_N_VC     = 4;
    localparam int unsigned DEF_WEIGHT_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index after idx, wrapping modulo n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_param_next_eligible.sv
// Rotating-priority finder: first set bit of eligible at or after start, wrapping.
module wrr_arbiter_param_next_eligible #(
    parameter int unsigned N_VC = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N_VC-1:0] eligible,
    input  logic [ID_W-1:0] start,
    output logic            found_c,
    output logic [ID_W-1:0] index_c
);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        found_c = 1'b0;
        index_c = '0;
        idx     = 32'd0;
        for (int k = int'(N_VC) - 1; k >= 0; k--) begin
            idx = 32'(start) + 32'(k);
            if (idx >= N_VC) begin
                idx = idx - N_VC;
            end
            if (eligible[ID_W'(idx)]) begin
                found_c = 1'b1;
                index_c = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter_param.sv
// Weighted round-robin arbiter over N_VC virtual channels with a runtime-editable
// weight table; forwards the granted channel's data bit to the output link.
module wrr_arbiter_param
    import wrr_arbiter_param_pkg::*;
#(
    parameter  int unsigned N_VC           = DEF_N_VC,
    parameter  int unsigned WEIGHT_W       = DEF_WEIGHT_W,
    parameter  int unsigned DEFAULT_WEIGHT = 1,
    localparam int unsigned ID_W           = $clog2(N_VC)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_VC-1:0]     req,
    input  logic [N_VC-1:0]     data_in,
    input  logic                edit_weight,
    input  logic [ID_W-1:0]     vc_assign,
    input  logic [WEIGHT_W-1:0] weight_assign,
    output logic                grant_valid,
    output logic [ID_W-1:0]     grant_id,
    output logic [N_VC-1:0]     grant_onehot,
    output logic [WEIGHT_W-1:0] credit,
    output logic                data_out
);

    logic [WEIGHT_W-1:0] weight_q [N_VC];
    state_t              state_q, state_nxt;
    logic [ID_W-1:0]     last_ptr_q, last_ptr_nxt;
    logic [ID_W-1:0]     grant_id_nxt;
    logic [WEIGHT_W-1:0] credit_nxt;
    logic [N_VC-1:0]     grant_onehot_nxt;
    logic [N_VC-1:0]     eligible;
    logic [ID_W-1:0]     search_start;
    logic                found_c;
    logic [ID_W-1:0]     pick_c;

    // Weight table; an index with no matching entry is simply not written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_VC); i++) begin
                weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else if (edit_weight) begin
            for (int i = 0; i < int'(N_VC); i++) begin
                if (vc_assign == ID_W'(i)) begin
                    weight_q[i] <= weight_assign;
                end
            end
        end
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(N_VC); i++) begin
            eligible[i] = req[i] && (weight_q[i] != '0);
        end
    end

    // Rotation resumes after the current grant, or after the last served VC when idle.
    assign search_start = (state_q == ST_GRANT)
                        ? ID_W'(wrap_inc(32'(grant_id), N_VC))
                        : ID_W'(wrap_inc(32'(last_ptr_q), N_VC));

    wrr_arbiter_param_next_eligible #(
        .N_VC (N_VC),
        .ID_W (ID_W)
    ) u_next_eligible (
        .eligible (eligible),
        .start    (search_start),
        .found_c  (found_c),
        .index_c  (pick_c)
    );

    always_comb begin
        state_nxt        = state_q;
        grant_id_nxt     = grant_id;
        credit_nxt       = credit;
        last_ptr_nxt     = last_ptr_q;
        grant_onehot_nxt = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_nxt    = ST_GRANT;
                    grant_id_nxt = pick_c;
                    credit_nxt   = weight_q[pick_c];
                end
            end
            ST_GRANT: begin
                if (eligible[grant_id] && (credit > WEIGHT_W'(1))) begin
                    credit_nxt = credit - WEIGHT_W'(1);
                end else begin
                    last_ptr_nxt = grant_id;
                    if (found_c) begin
                        grant_id_nxt = pick_c;
                        credit_nxt   = weight_q[pick_c];
                    end else begin
                        state_nxt  = ST_IDLE;
                        credit_nxt = '0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        for (int i = 0; i < int'(N_VC); i++) begin
            if ((state_nxt == ST_GRANT) && (grant_id_nxt == ID_W'(i))) begin
                grant_onehot_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_ptr_q   <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            grant_onehot <= '0;
            credit       <= '0;
        end else begin
            state_q      <= state_nxt;
            last_ptr_q   <= last_ptr_nxt;
            grant_valid  <= (state_nxt == ST_GRANT);
            grant_id     <= grant_id_nxt;
            grant_onehot <= grant_onehot_nxt;
            credit       <= credit_nxt;
        end
    end

    assign data_out = grant_valid & data_in[grant_id];

endmodule

// File: tb/tb_wrr_arbiter_param.sv
// Randomised self-checking bench for wrr_arbiter_param against a behavioural WRR model.
module tb_wrr_arbiter_param;

    localparam int N  = 4;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  data_in = '0;
    logic          edit_weight = 1'b0;
    logic [1:0]    vc_assign = '0;
    logic [WW-1:0] weight_assign = '0;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic [N-1:0]  grant_onehot;
    logic [WW-1:0] credit;
    logic          data_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int w_m [N];
    bit valid_m;
    int id_m, credit_m, last_m;

    wrr_arbiter_param #(.N_VC(N), .WEIGHT_W(WW), .DEFAULT_WEIGHT(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .data_in       (data_in),
        .edit_weight   (edit_weight),
        .vc_assign     (vc_assign),
        .weight_assign (weight_assign),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .grant_onehot  (grant_onehot),
        .credit        (credit),
        .data_out      (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        valid_m  = 1'b0;
        id_m     = 0;
        credit_m = 0;
        last_m   = 0;
        for (int i = 0; i < N; i++) w_m[i] = 1;
    endtask

    // One clock of arbitration using the table as it stood before this edge's edit.
    task automatic model_step();
        bit elig [N];
        int start;
        bit found;
        int pick;
        for (int i = 0; i < N; i++) elig[i] = req[i] && (w_m[i] != 0);
        if (valid_m && elig[id_m] && credit_m > 1) begin
            credit_m = credit_m - 1;
        end else begin
            start = valid_m ? id_m : last_m;
            if (valid_m) last_m = id_m;
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && elig[(start + k) % N]) begin
                    found = 1'b1;
                    pick  = (start + k) % N;
                end
            end
            if (found) begin
                valid_m  = 1'b1;
                id_m     = pick;
                credit_m = w_m[pick];
            end else begin
                valid_m  = 1'b0;
                credit_m = 0;
            end
        end
        if (edit_weight) w_m[int'(vc_assign)] = int'(weight_assign);
    endtask

    task automatic check_outputs(input string ph);
        logic [N-1:0] d;
        d = data_in;
        check({ph, ".valid"},  32'(grant_valid),  32'(valid_m));
        check({ph, ".id"},     32'(grant_id),     32'(id_m));
        check({ph, ".onehot"}, 32'(grant_onehot), valid_m ? (32'd1 << id_m) : 32'd0);
        check({ph, ".credit"}, 32'(credit),       32'(credit_m));
        check({ph, ".data"},   32'(data_out),     valid_m ? 32'((d >> id_m) & 4'd1) : 32'd0);
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d, input bit e,
                         input int vc, input int wv, input string ph);
        req           = r;
        data_in       = d;
        edit_weight   = e;
        vc_assign     = 2'(vc);
        weight_assign = WW'(wv);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(ph);
    endtask

    // Reset between edges: outputs must clear before any clock arrives.
    task automatic async_reset();
        #2;
        reset       = 1'b1;
        edit_weight = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_outputs("por");
        #20;
        reset = 1'b0;

        // Default weight of 1 after reset
        cycle(4'b0100, 4'b0100, 0, 0, 0, "def_w");
        check("def_w.credit_const", 32'(credit), 32'd1);
        cycle(4'b0000, 4'b0000, 0, 0, 0, "def_w_idle");

        // Weights {1,2,3,4}, all requesting
        for (int i = 0; i < N; i++) cycle(4'b0000, 4'b0000, 1, i, i + 1, "wr_w");
        for (int c = 0; c < 20; c++) cycle(4'b1111, 4'(c), 0, 0, 0, "all_req");

        // Single requester bursts back to back
        cycle(4'b0000, 4'b0000, 1, 2, 3, "w2_3");
        for (int c = 0; c < 8; c++) cycle(4'b0100, 4'b0100, 0, 0, 0, "solo2");

        // Disabled VC1
        cycle(4'b0000, 4'b0000, 1, 1, 0, "w1_0");
        for (int c = 0; c < 10; c++) cycle(4'b0011, 4'b0010, 0, 0, 0, "vc1_off");

        // Request drop mid-burst, then all requests gone
        cycle(4'b0000, 4'b0000, 1, 3, 2, "w3_2");
        for (int c = 0; c < 6; c++) cycle(4'b1001, 4'b1000, 0, 0, 0, "pre_drop");
        cycle(4'b0001, 4'b1001, 0, 0, 0, "drop");
        cycle(4'b0000, 4'b1111, 0, 0, 0, "none");
        cycle(4'b0000, 4'b1111, 0, 0, 0, "none2");

        // Edit running VC's weight mid-burst
        for (int c = 0; c < 3; c++) cycle(4'b1000, 4'b1000, 0, 0, 0, "v3");
        cycle(4'b1000, 4'b1000, 1, 3, 5, "edit_v3");
        for (int c = 0; c < 12; c++) cycle(4'b1000, 4'b1000, 0, 0, 0, "v3_after");

        // Data mux
        cycle(4'b0100, 4'b0100, 0, 0, 0, "mux2");
        cycle(4'b0010, 4'b0100, 1, 1, 2, "mux1a");
        for (int c = 0; c < 4; c++) cycle(4'b0010, 4'b0100, 0, 0, 0, "mux1");

        async_reset();

        // Randomised traffic with edits and occasional async resets
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] r;
            bit e;
            r = (($urandom_range(0, 3) == 0) ? 4'($urandom) : (req | 4'($urandom_range(0, 1))) & ~4'($urandom_range(0, 1) << $urandom_range(0, 3)));
            e = ($urandom_range(0, 7) == 0);
            cycle(r, 4'($urandom), e, $urandom_range(0, N - 1), $urandom_range(0, 7), "rand");
            if (c % 500 == 499) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
